// File: rtl/soc_prog_pkg.sv
// Shared opcodes, state encoding and response constants for the SoC bus programmer.
package soc_prog_pkg;

    localparam logic [7:0] OP_WRITE         = 8'h01;
    localparam logic [7:0] OP_READ          = 8'h02;
    localparam logic [7:0] OP_WRITE_MASKED  = 8'h03;

    localparam logic [7:0] DEFAULT_ACK_BYTE = 8'hAA;
    localparam logic [7:0] DEFAULT_NAK_BYTE = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        MASK,
        BUS,
        RESP
    } prog_state_t;

    function automatic logic opcode_is_valid(input logic [7:0] op);
        return (op == OP_WRITE) || (op == OP_READ) || (op == OP_WRITE_MASKED);
    endfunction

endpackage

// File: rtl/soc_mem_bus.sv
// Single-word SoC memory bus between a master and the interconnect.
interface SoC_MemBus;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        write_en;
    logic [3:0]  byte_en;
    logic        req;
    logic [31:0] read_data;
    logic        valid;

    modport Master (
        output addr, write_data, write_en, byte_en, req,
        input  read_data, valid
    );

    modport Slave (
        input  addr, write_data, write_en, byte_en, req,
        output read_data, valid
    );
endinterface

// File: rtl/soc_prog_tx_serializer.sv
// Sends the low `count` bytes of a word LSB first over a valid/ready byte link.
module soc_prog_tx_serializer (
    input  logic        clk,
    input  logic        res,
    input  logic        load,
    input  logic [31:0] word,
    input  logic [2:0]  count,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        last
);

    logic [31:0] word_q;
    logic [2:0]  remain_q;
    logic        tx_valid_q;
    logic        fire;

    assign fire     = tx_valid_q && tx_ready;
    assign last     = fire && (remain_q == 3'd1);
    assign tx_data  = word_q[7:0];
    assign tx_valid = tx_valid_q;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            word_q     <= '0;
            remain_q   <= '0;
            tx_valid_q <= 1'b0;
        end else if (load) begin
            word_q     <= word;
            remain_q   <= count;
            tx_valid_q <= (count != 3'd0);
        end else if (fire) begin
            if (remain_q == 3'd1) begin
                remain_q   <= '0;
                tx_valid_q <= 1'b0;
            end else begin
                word_q   <= {8'h00, word_q[31:8]};
                remain_q <= remain_q - 3'd1;
            end
        end
    end

endmodule

// File: rtl/soc_bus_programmer.sv
// UART-framed bus master: decodes WRITE/READ/WRITE_MASKED frames into single SoC_MemBus transfers.
// Optional inter-byte timeout enabled by defining SOC_PROG_TIMEOUT_EN.
module soc_bus_programmer
    import soc_prog_pkg::*;
#(
    parameter logic [7:0]  ACK_BYTE       = DEFAULT_ACK_BYTE,
    parameter logic [7:0]  NAK_BYTE       = DEFAULT_NAK_BYTE,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             res,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    SoC_MemBus.Master        bus,
    output logic             busy,
    output logic             rx_overrun
);

    prog_state_t state_q, state_d;
    logic [1:0]  cnt_q;
    logic [7:0]  opcode_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  mask_q;
    logic        overrun_q;

    logic        in_bus;
    logic        collecting;
    logic        byte_last;
    logic        timeout;
    logic        ser_load;
    logic [31:0] ser_word;
    logic [2:0]  ser_count;
    logic        ser_last;

    assign in_bus     = (state_q == BUS);
    assign collecting = (state_q == ADDR) || (state_q == DATA) || (state_q == MASK);
    assign byte_last  = rx_valid && (cnt_q == 2'd3);

`ifdef SOC_PROG_TIMEOUT_EN
    logic [31:0] idle_cnt_q;

    assign timeout = collecting && !rx_valid && (idle_cnt_q == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            idle_cnt_q <= '0;
        end else if (rx_valid || !collecting) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_q + 32'd1;
        end
    end
`else
    localparam int unsigned TIMEOUT_UNUSED = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ser_load  = 1'b0;
        ser_word  = '0;
        ser_count = '0;
        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    if (opcode_is_valid(rx_data)) begin
                        state_d = ADDR;
                    end else begin
                        state_d   = RESP;
                        ser_load  = 1'b1;
                        ser_word  = {24'h0, NAK_BYTE};
                        ser_count = 3'd1;
                    end
                end
            end
            ADDR: begin
                if (byte_last) begin
                    state_d = (opcode_q == OP_READ) ? BUS : DATA;
                end
            end
            DATA: begin
                if (byte_last) begin
                    state_d = (opcode_q == OP_WRITE_MASKED) ? MASK : BUS;
                end
            end
            MASK: begin
                if (rx_valid) begin
                    state_d = BUS;
                end
            end
            BUS: begin
                // A valid in the first req cycle (interconnect fallback) completes the transfer too.
                if (bus.valid) begin
                    state_d  = RESP;
                    ser_load = 1'b1;
                    if (opcode_q == OP_READ) begin
                        ser_word  = bus.read_data;
                        ser_count = 3'd4;
                    end else begin
                        ser_word  = {24'h0, ACK_BYTE};
                        ser_count = 3'd1;
                    end
                end
            end
            RESP: begin
                if (ser_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (timeout) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            cnt_q     <= '0;
            opcode_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mask_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= rx_valid && (in_bus || (state_q == RESP));
            if (rx_valid) begin
                case (state_q)
                    IDLE: begin
                        opcode_q <= rx_data;
                        cnt_q    <= '0;
                    end
                    ADDR: begin
                        addr_q[{cnt_q, 3'b000} +: 8] <= rx_data;
                        cnt_q                        <= cnt_q + 2'd1;
                    end
                    DATA: begin
                        wdata_q[{cnt_q, 3'b000} +: 8] <= rx_data;
                        cnt_q                         <= cnt_q + 2'd1;
                    end
                    MASK:    mask_q <= rx_data[3:0];
                    default: ;
                endcase
            end
        end
    end

    soc_prog_tx_serializer u_tx_serializer (
        .clk      (clk),
        .res      (res),
        .load     (ser_load),
        .word     (ser_word),
        .count    (ser_count),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .last     (ser_last)
    );

    // Bus controls derive from the state register so reset drops req without waiting for a clock.
    assign bus.req        = in_bus;
    assign bus.addr       = addr_q;
    assign bus.write_data = wdata_q;
    assign bus.write_en   = in_bus && (opcode_q != OP_READ);
    assign bus.byte_en    = in_bus ? ((opcode_q == OP_WRITE_MASKED) ? mask_q : 4'hF) : 4'h0;

    assign busy       = (state_q != IDLE);
    assign rx_overrun = overrun_q;

endmodule
